// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Brief    : Full-duplex 8N1/8E1/8O1 UART, shared 16x baud generator.
//            Optional UART_LOOPBACK_EN adds a loopback input (tx -> rx path).
// Revision : 1.0 - initial release
// ============================================================================
module uart_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic       tx,
    output logic       busy,
    input  logic       rx,
`ifdef UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int c_div_raw = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_parity = 3'd3;
    localparam logic [2:0] c_stop   = 3'd4;
    localparam logic [2:0] c_wait_h = 3'd5;

    logic [c_div_w-1:0] baud_cnt_q;
    logic               w_tick;

    assign w_tick = (baud_cnt_q == c_div_last);

    always_ff @(posedge clk) begin
        if (!reset)      baud_cnt_q <= '0;
        else if (w_tick) baud_cnt_q <= '0;
        else             baud_cnt_q <= baud_cnt_q + 1'b1;
    end

    logic [2:0] tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tx_par_en_q, tx_par_en_d;
    logic       tx_par_bit_q, tx_par_bit_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q   <= c_idle;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_tick_q    <= tx_tick_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
        end
    end

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_tick_d    = tx_tick_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        if (tx_state_q == c_idle) begin
            if (in_valid) begin
                tx_state_d   = c_start;
                tx_tick_d    = '0;
                tx_bit_d     = '0;
                tx_shift_d   = in_data;
                tx_par_en_d  = parity_en;
                tx_par_bit_d = (^in_data) ^ parity_odd;
            end
        end else if (w_tick) begin
            if (tx_tick_q == 4'd15) begin
                tx_tick_d = '0;
                case (tx_state_q)
                    c_start: tx_state_d = c_data;
                    c_data: begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7)
                            tx_state_d = tx_par_en_q ? c_parity : c_stop;
                    end
                    c_parity: tx_state_d = c_stop;
                    default:  tx_state_d = c_idle;
                endcase
            end else begin
                tx_tick_d = tx_tick_q + 4'd1;
            end
        end
    end

    always_comb begin
        tx       = 1'b1;
        busy     = 1'b1;
        in_ready = 1'b0;
        case (tx_state_q)
            c_idle: begin
                busy     = 1'b0;
                in_ready = 1'b1;
            end
            c_start:  tx = 1'b0;
            c_data:   tx = tx_shift_q[0];
            c_parity: tx = tx_par_bit_q;
            default:  tx = 1'b1;
        endcase
    end

    logic       w_rx_src;
    logic [1:0] rx_sync_q;
    logic       w_rx_s;

`ifdef UART_LOOPBACK_EN
    assign w_rx_src = loopback ? tx : rx;
`else
    assign w_rx_src = rx;
`endif
    assign w_rx_s = rx_sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) rx_sync_q <= 2'b11;
        else        rx_sync_q <= {rx_sync_q[0], w_rx_src};
    end

    logic [2:0] rx_state_q, rx_state_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_par_en_q, rx_par_en_d;
    logic       rx_par_odd_q, rx_par_odd_d;
    logic       rx_par_bit_q, rx_par_bit_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q   <= c_idle;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bit_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bit_q <= rx_par_bit_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tick_d    = rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bit_d = rx_par_bit_q;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        case (rx_state_q)
            c_idle: begin
                if (w_tick && !w_rx_s) begin
                    rx_state_d = c_start;
                    rx_tick_d  = '0;
                end
            end
            c_start: begin
                if (w_tick) begin
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d = '0;
                        if (!w_rx_s) begin
                            rx_state_d   = c_data;
                            rx_bit_d     = '0;
                            rx_par_en_d  = parity_en;
                            rx_par_odd_d = parity_odd;
                        end else begin
                            rx_state_d = c_idle;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            c_data, c_parity, c_stop: begin
                if (w_tick) begin
                    if (rx_tick_q == 4'd15) begin
                        rx_tick_d = '0;
                        if (rx_state_q == c_data) begin
                            rx_shift_d = {w_rx_s, rx_shift_q[7:1]};
                            rx_bit_d   = rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'd7)
                                rx_state_d = rx_par_en_q ? c_parity : c_stop;
                        end else if (rx_state_q == c_parity) begin
                            rx_par_bit_d = w_rx_s;
                            rx_state_d   = c_stop;
                        end else begin
                            // A completing frame overrides any pending consume.
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_shift_q;
                            ferr_d     = !w_rx_s;
                            perr_d     = rx_par_en_q &
                                         (rx_par_bit_q ^ (^rx_shift_q) ^ rx_par_odd_q);
                            rx_state_d = w_rx_s ? c_idle : c_wait_h;
                        end
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
            end
            default: begin
                if (w_rx_s) rx_state_d = c_idle;
            end
        endcase
    end

    always_comb begin
        rx_valid   = rx_valid_q;
        rx_data    = rx_data_q;
        parity_err = perr_q;
        frame_err  = ferr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core
// Brief    : Scoreboard bench for uart_core (loopback via bench wiring).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    localparam int BITP  = 432;
    localparam int HALF  = 216;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_ready = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_sel = 1'b1;
    logic       in_ready, tx, busy, rx_valid, parity_err, frame_err;
    logic [7:0] rx_data;
    logic       rx;

    assign rx = loop_sel ? tx : rx_drv;

    uart_core dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx), .busy(busy), .rx(rx),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx: got byte %0h expected none", rx_data);
            end else begin
                e = q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        while (!in_ready && n < LIMIT) begin @(negedge clk); n++; end
        chk("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_tx_low(output int t);
        int n = 0;
        while (tx !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
        chk("tx_start", {31'd0, tx}, 32'd0);
        t = cyc;
    endtask

    task automatic wait_busy_low(output int t);
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
        chk("busy_end", {31'd0, busy}, 32'd0);
        t = cyc;
    endtask

    task automatic sample_wave(input logic [10:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            repeat ((i == 0) ? HALF : BITP) @(negedge clk);
            chk($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, bits[i]});
        end
    endtask

    task automatic tx_frame(input logic [7:0] d, input bit push, input logic [10:0] bits,
                            input int nb, output int len);
        int t0, t1;
        in_data  = d;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        if (push) q.push_back('{d: d, pe: 1'b0, fe: 1'b0});
        wait_tx_low(t0);
        if (nb > 0) sample_wave(bits, nb);
        wait_busy_low(t1);
        len = t1 - t0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit pen, input bit pbit,
                            input bit stop, input int extra_low);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BITP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BITP) @(negedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (BITP) @(negedge clk);
        end
        rx_drv = stop;
        repeat (BITP + extra_low) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    int len, t1, t2;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b1;

        // 0x55 even parity, loopback: start, 10101010, parity 0, stop
        loop_sel = 1'b1; parity_en = 1'b1; parity_odd = 1'b0;
        tx_frame(8'h55, 1'b1, 11'b1_0_01010101_0, 11, len);
        chk("len_11bit", {31'd0, (len >= 4726 && len <= 4752)}, 32'd1);

        // back-to-back 0xA3 then 0x00, odd parity, in_valid held
        parity_odd = 1'b1;
        in_data  = 8'hA3;
        in_valid = 1'b1;
        wait_accept();
        in_data = 8'h00;
        q.push_back('{d: 8'hA3, pe: 1'b0, fe: 1'b0});
        wait_tx_low(t1);
        sample_wave(11'b1_1_10100011_0, 11);
        wait_busy_low(t1);
        wait_accept();
        in_valid = 1'b0;
        q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0});
        wait_tx_low(t2);
        chk("b2b_gap", t2 - t1, 32'd1);
        sample_wave(11'b1_1_00000000_0, 11);
        wait_busy_low(t2);

        // no parity, 0xFF: 10-bit frame
        parity_en = 1'b0; parity_odd = 1'b0;
        tx_frame(8'hFF, 1'b1, 11'b0_1_11111111_0, 10, len);
        chk("len_10bit", {31'd0, (len >= 4294 && len <= 4320)}, 32'd1);

        // bench-driven frames: bad parity, frame error with break, recovery
        loop_sel = 1'b0; parity_en = 1'b1; parity_odd = 1'b0;
        q.push_back('{d: 8'h3C, pe: 1'b1, fe: 1'b0});
        rx_frame(8'h3C, 1'b1, 1'b1, 1'b1, 0);
        repeat (100) @(negedge clk);
        parity_en = 1'b0;
        q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b1});
        rx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2 * BITP);
        repeat (100) @(negedge clk);
        q.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        rx_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0);
        repeat (100) @(negedge clk);

        // overrun: two frames while rx_ready low
        loop_sel = 1'b1; parity_en = 1'b1; rx_ready = 1'b0;
        tx_frame(8'h11, 1'b0, 11'd0, 0, len);
        tx_frame(8'h22, 1'b0, 11'd0, 0, len);
        @(negedge clk);
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_data", {24'd0, rx_data}, 32'h22);
        q.push_back('{d: 8'h22, pe: 1'b0, fe: 1'b0});
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid_clear", {31'd0, rx_valid}, 32'd0);

        // reset mid-transmission
        in_data = 8'h5A; in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (1000) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        tx_frame(8'h96, 1'b1, 11'b1_0_10010110_0, 11, len);
        repeat (100) @(negedge clk);

        // single-clock glitches at varying baud phases: no frames
        loop_sel = 1'b0; rx_drv = 1'b1;
        for (int k = 0; k < 27; k++) begin
            repeat (301) @(negedge clk);
            rx_drv = 1'b0;
            @(negedge clk);
            rx_drv = 1'b1;
        end
        repeat (6000) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_core.md
Name: uart_core

Overview:
Full-duplex 8-bit UART with a shared 16x oversampling baud generator, a transmitter and a receiver, all in one clock domain. Both directions use a valid/ready byte interface toward the system side. Parity (even/odd/none) is selectable at run time. One start bit and one stop bit per frame.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line bit rate in bit/s
OVERSAMPLE, 16, oversample ticks per bit; fixed at 16, other values unsupported

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous active-low reset (0 = reset, sampled on clk rising edge)
in_valid  in  1  TX byte offered
in_ready  out  1  TX can accept a byte
in_data  in  8  TX byte
parity_en  in  1  1 = parity bit present (TX and RX)
parity_odd  in  1  1 = odd parity, 0 = even parity
tx  out  1  serial output, idle high
busy  out  1  TX frame in progress
rx  in  1  serial input, asynchronous, idle high
rx_valid  out  1  received byte available
rx_ready  in  1  consumer takes received byte
rx_data  out  8  received byte
parity_err  out  1  parity mismatch on the byte in rx_data
frame_err  out  1  stop bit was 0 on the byte in rx_data

Behaviour:
- Reset (reset==0 at a clk edge): all state cleared; tx=1, busy=0, in_ready=1, rx_valid=0, rx_data=0, parity_err=0, frame_err=0. Reset mid-frame aborts both directions immediately; a partial frame is discarded.
- Baud generator: DIV = round(CLK_FREQ/(BAUD*16)), minimum 1 (27 for defaults). Counter 0..DIV-1. oversample_tick is a 1-cycle pulse when counter==DIV-1. Free-running after reset; never gated.
- Bit period = 16 oversample ticks.
- TX states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, in_ready=1, busy=0.
  - Accept occurs when in_valid && in_ready. The TX latches in_data, parity_en and parity_odd at accept; later input changes do not affect the frame.
  - The next cycle enters START: tx=0, busy=1, in_ready=0.
  - DATA: 8 bits, LSB first.
  - PARITY (only if the latched parity_en is 1): bit = XOR(data) for even, ~XOR(data) for odd.
  - STOP: tx=1 for 16 ticks, then IDLE.
  - Each state lasts exactly 16 oversample ticks, except START, which may be shortened by less than one tick period due to alignment.
  - in_valid while busy is ignored; there is no queueing.
- RX: the rx input passes through a 2-flop synchronizer (reset value 1).
- RX states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: synchronized rx==0 on an oversample tick enters START.
  - START: after 8 ticks, resample. If 0, go to DATA; if 1 (false start), go to IDLE.
  - DATA: sample every 16 ticks at bit centre, 8 bits, LSB first.
  - PARITY: present only if parity_en is 1; parity_en and parity_odd are sampled at the start-bit centre.
  - STOP: sample at centre. On this cycle rx_data, parity_err and frame_err are updated and rx_valid is set to 1.
  - frame_err = (stop sample == 0).
  - parity_err = mismatch against the configured parity; it is 0 when parity is disabled.
  - After STOP, go to IDLE if the stop sample is 1, else go to WAIT_HIGH, which waits for synchronized rx==1 before IDLE. This handles break conditions.
- RX output handshake: rx_valid, rx_data and the error flags hold until rx_valid && rx_ready at a clk edge, then rx_valid clears the next cycle.
  - Overrun: if a new frame completes while rx_valid==1, the new data and flags overwrite the old ones and rx_valid stays 1.
  - If rx_ready and frame completion happen in the same cycle, the new byte wins and rx_valid stays 1.
- Latency: a frame is (10 + parity_en) × 16 × DIV clocks; 11-bit frame = 4752 clocks at defaults. rx_valid rises near the middle of the stop bit.

Optional Feature:
UART_LOOPBACK_EN. When defined, an extra input port loopback (1 bit) exists. With loopback==1, the RX synchronizer input is the internal tx signal and the rx pin is ignored; tx still drives the pin. When not defined, the port is absent and RX always uses rx.

Test Plan:
- tx wired to rx, parity_en=1, parity_odd=0; send 0x55 -> tx waveform 0,1010101 0 (LSB first),0,1; rx_valid, rx_data=0x55, parity_err=0, frame_err=0; frame length 4752 clocks.
- Loop, parity_odd=1; send 0xA3 then 0x00 back-to-back (in_valid held) -> second byte accepted only after STOP ends; both received with no errors; parity bits 1 then 1.
- parity_en=0; send 0xFF -> 10-bit frame (4320 clocks); rx_data=0xFF, no errors.
- Bench drives rx with byte 0x3C, even parity bit wrong -> rx_data=0x3C, parity_err=1; separate frame with stop=0 -> frame_err=1; RX then waits for rx high before accepting the next start.
- rx_ready held 0 across two received frames (0x11, 0x22) -> rx_valid stays 1, rx_data=0x22; rx_ready pulse -> rx_valid=0 next cycle.
- Assert reset (0) mid-transmission -> next cycle tx=1, busy=0, in_ready=1, rx_valid=0; a subsequent frame is received correctly; a 1-clock glitch low on rx -> no rx_valid (false start).
